// File: rtl/common_pkg.sv
// Shared CRTC definitions: register-file geometry and the register-writer FSM states.
package common_pkg;

    localparam int CRTC_REG_COUNT = 18;
    localparam int CRTC_REG_WIDTH = 5;

    typedef enum logic [2:0] {
        IDLE,
        SEL_WAIT,
        SEL_HOLD,
        WR_WAIT,
        WR_HOLD
    } crtc_wr_state_t;

endpackage : common_pkg

// File: rtl/video_crtc_writer.sv
// Bus initiator for the 6545-style CRTC register port: turns one (register, value)
// request into an index-select cycle and a data-write cycle, each aligned to clk_en_i.
module video_crtc_writer
    import common_pkg::*;
#(
    parameter bit SKIP_RESELECT = 1'b1,
    parameter int REG_WIDTH     = CRTC_REG_WIDTH
) (
    input  logic                 sys_clock_i,
    input  logic                 reset_i,
    input  logic                 clk_en_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [REG_WIDTH-1:0] req_reg_i,
    input  logic [7:0]           req_data_i,
    output logic                 cs_o,
    output logic                 rs_o,
    output logic                 we_o,
    output logic [7:0]           data_o,
    output logic                 busy_o,
    output logic                 done_o
);

    crtc_wr_state_t       state_q, state_d;
    logic                 cs_q, cs_d;
    logic                 rs_q, rs_d;
    logic                 we_q, we_d;
    logic [7:0]           data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [REG_WIDTH-1:0] sel_reg_q, sel_reg_d;
    logic                 sel_valid_q, sel_valid_d;
    logic [REG_WIDTH-1:0] req_reg_q, req_reg_d;
    logic [7:0]           req_data_q, req_data_d;

    // Masking with done_q delays ready by one cycle so it appears the cycle after done_o.
    assign req_ready_o = (state_q == IDLE) && !done_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        cs_d        = cs_q;
        rs_d        = rs_q;
        we_d        = we_q;
        data_d      = data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sel_reg_d   = sel_reg_q;
        sel_valid_d = sel_valid_q;
        req_reg_d   = req_reg_q;
        req_data_d  = req_data_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    req_reg_d  = req_reg_i;
                    req_data_d = req_data_i;
                    busy_d     = 1'b1;
                    if (SKIP_RESELECT && sel_valid_q && (req_reg_i == sel_reg_q)) begin
                        state_d = WR_WAIT;
                    end else begin
                        state_d = SEL_WAIT;
                    end
                end
            end
            SEL_WAIT: begin
                if (clk_en_i) begin
                    cs_d    = 1'b1;
                    rs_d    = 1'b0;
                    we_d    = 1'b1;
                    data_d  = 8'(req_reg_q);
                    state_d = SEL_HOLD;
                end
            end
            SEL_HOLD: begin
                // The responder latches the index on this strobe; release after it.
                if (clk_en_i) begin
                    cs_d        = 1'b0;
                    we_d        = 1'b0;
                    sel_reg_d   = req_reg_q;
                    sel_valid_d = 1'b1;
                    state_d     = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (clk_en_i) begin
                    cs_d    = 1'b1;
                    rs_d    = 1'b1;
                    we_d    = 1'b1;
                    data_d  = req_data_q;
                    state_d = WR_HOLD;
                end
            end
            WR_HOLD: begin
                if (clk_en_i) begin
                    cs_d    = 1'b0;
                    rs_d    = 1'b0;
                    we_d    = 1'b0;
                    data_d  = 8'h00;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Asynchronous reset releases the bus at once and forgets the selected index,
    // so the first request after reset always issues a select cycle.
    always_ff @(posedge sys_clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cs_q        <= 1'b0;
            rs_q        <= 1'b0;
            we_q        <= 1'b0;
            data_q      <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sel_reg_q   <= '0;
            sel_valid_q <= 1'b0;
            req_reg_q   <= '0;
            req_data_q  <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments make every register update from pre-edge values, independent of statement order.
            state_q     <= state_d;
            cs_q        <= cs_d;
            rs_q        <= rs_d;
            we_q        <= we_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sel_reg_q   <= sel_reg_d;
            sel_valid_q <= sel_valid_d;
            req_reg_q   <= req_reg_d;
            req_data_q  <= req_data_d;
        end
    end

    assign cs_o   = cs_q;
    assign rs_o   = rs_q;
    assign we_o   = we_q;
    assign data_o = data_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule : video_crtc_writer
